// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier that handles one multiplier bit per clock.
// It supports unsigned or two's-complement operands and uses a start/busy/done handshake.
module seq_shift_add_mult #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // state | meaning
    // IDLE  | waiting for start
    // BUSY  | iterating, one multiplier bit per cycle
    // DONE  | product updated this cycle; start is accepted again
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mcand;
    logic               smode;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               zero_op;
    logic               last;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shifted;

    always_comb begin
        accept  = start && (state == IDLE || state == DONE);
        zero_op = EARLY_ZERO && (operand_a == '0 || operand_b == '0);
        last    = (cnt == CW'(1));
    end

    // The final iteration weighs the multiplier MSB negatively in signed mode.
    always_comb begin
        addend = smode ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
        sum    = acc;
        if (mplier[0])
            sum = (smode && last) ? acc - addend : acc + addend;
        shifted = {smode & sum[WIDTH], sum, mplier[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = zero_op ? DONE : BUSY;
            BUSY: if (last) state_nxt = DONE;
            DONE: begin
                if (start)
                    state_nxt = zero_op ? DONE : BUSY;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mplier  <= '0;
            mcand   <= '0;
            smode   <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            acc    <= '0;
            mplier <= operand_b;
            mcand  <= operand_a;
            smode  <= signed_mode;
            cnt    <= CW'(WIDTH);
            if (zero_op)
                product <= '0;
        end else if (state == BUSY) begin
            acc    <= shifted[2*WIDTH:WIDTH];
            mplier <= shifted[WIDTH-1:0];
            cnt    <= cnt - CW'(1);
            if (last)
                product <= shifted[2*WIDTH-1:0];
        end
    end

    always_comb begin
        busy = (state == BUSY);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed testbench for seq_shift_add_mult. It uses two 8-bit instances, one for each
// EARLY_ZERO setting, and a 16-bit instance that is checked against a behavioural product.
module tb_seq_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sm = 1'b0;
    logic        start8 = 1'b0, start8z = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;

    logic        busy8, done8, busy8z, done8z, busy16, done16;
    logic [15:0] prod8, prod8z;
    logic [31:0] prod16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_shift_add_mult #(.WIDTH(8), .EARLY_ZERO(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm),
        .operand_a(a8), .operand_b(b8),
        .busy(busy8), .done(done8), .product(prod8));

    seq_shift_add_mult #(.WIDTH(8), .EARLY_ZERO(1'b0)) dut8z (
        .clk(clk), .rst(rst), .start(start8z), .signed_mode(sm),
        .operand_a(a8), .operand_b(b8),
        .busy(busy8z), .done(done8z), .product(prod8z));

    seq_shift_add_mult #(.WIDTH(16), .EARLY_ZERO(1'b0)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm),
        .operand_a(a16), .operand_b(b16),
        .busy(busy16), .done(done16), .product(prod16));

    // One 8-bit operation: start it, count edges until done, then check the result,
    // the latency, that busy stayed high while waiting, and that done is a single pulse.
    task automatic op8(input bit use_z, input bit s, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input int exp_lat, input string name);
        int lat;
        bit busy_bad;
        @(negedge clk);
        sm = s; a8 = a; b8 = b;
        if (use_z) start8z = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start8z = 1'b0;
        lat = 0;
        busy_bad = 1'b0;
        while (!(use_z ? done8z : done8) && lat < 40) begin
            if ((use_z ? busy8z : busy8) !== 1'b1) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_vec++;
        if ((use_z ? prod8z : prod8) !== exp) begin
            n_err++;
            $display("FAIL %s product: got %h expected %h", name, use_z ? prod8z : prod8, exp);
        end
        n_vec++;
        if (busy_bad || (use_z ? busy8z : busy8) !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy: got bad=%0b busy_at_done=%b expected bad=0 busy_at_done=0",
                     name, busy_bad, use_z ? busy8z : busy8);
        end
        @(negedge clk);
        n_vec++;
        if ((use_z ? done8z : done8) !== 1'b0 || (use_z ? prod8z : prod8) !== exp) begin
            n_err++;
            $display("FAIL %s pulse/hold: got done=%b product=%h expected done=0 product=%h",
                     name, use_z ? done8z : done8, use_z ? prod8z : prod8, exp);
        end
    endtask

    task automatic op16(input bit s, input logic [15:0] a, input logic [15:0] b);
        int lat;
        logic [31:0] exp;
        logic signed [31:0] sp;
        sp  = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        exp = s ? sp : ({16'h0, a} * {16'h0, b});
        @(negedge clk);
        sm = s; a16 = a; b16 = b; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== 16 || prod16 !== exp) begin
            n_err++;
            $display("FAIL w16 s=%0b %h*%h: got lat=%0d product=%h expected lat=16 product=%h",
                     s, a, b, lat, prod16, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy8, done8, busy8z, done8z, busy16, done16} !== 6'b0 ||
            prod8 !== 16'h0 || prod8z !== 16'h0 || prod16 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: got busy/done=%b products=%h %h %h expected all zero",
                     {busy8, done8, busy8z, done8z, busy16, done16}, prod8, prod8z, prod16);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        op8(1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8, "u_ff_ff");
        op8(1'b0, 1'b0, 8'hFF, 8'h01, 16'h00FF, 8, "u_ff_01");
        op8(1'b1, 1'b0, 8'h03, 8'h05, 16'h000F, 8, "u_03_05_ez0");
    endtask

    task automatic test_signed();
        op8(1'b0, 1'b1, 8'h80, 8'h80, 16'h4000, 8, "s_80_80");
        op8(1'b0, 1'b1, 8'h7F, 8'h80, 16'hC080, 8, "s_7f_80");
        op8(1'b0, 1'b1, 8'hFF, 8'h01, 16'hFFFF, 8, "s_ff_01");
        op8(1'b0, 1'b1, 8'hFD, 8'h05, 16'hFFF1, 8, "s_fd_05");
        op8(1'b0, 1'b1, 8'h7F, 8'h7F, 16'h3F01, 8, "s_7f_7f");
    endtask

    task automatic test_zero();
        op8(1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8, "z_preload");
        op8(1'b0, 1'b0, 8'h00, 8'h5A, 16'h0000, 0, "z_early");
        op8(1'b1, 1'b0, 8'h00, 8'h5A, 16'h0000, 8, "z_full");
        op8(1'b0, 1'b1, 8'h5A, 8'h00, 16'h0000, 0, "z_early_b");
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        sm = 1'b0; a8 = 8'h37; b8 = 8'h12; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        repeat (3) begin @(negedge clk); lat++; end
        a8 = 8'hAA; b8 = 8'h55; sm = 1'b1; start8 = 1'b1;
        @(negedge clk); lat++;
        start8 = 1'b0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== 8 || prod8 !== 16'h03DE) begin
            n_err++;
            $display("FAIL ignore_start: got lat=%0d product=%h expected lat=8 product=03de",
                     lat, prod8);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        sm = 1'b0; a8 = 8'h0F; b8 = 8'h0F; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== 8 || prod8 !== 16'h00E1) begin
            n_err++;
            $display("FAIL b2b_first: got lat=%0d product=%h expected lat=8 product=00e1", lat, prod8);
        end
        a8 = 8'h10; b8 = 8'h10; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n_vec++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || prod8 !== 16'h00E1) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%b done=%b product=%h expected busy=1 done=0 product=00e1",
                     busy8, done8, prod8);
        end
        lat = 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== 8 || prod8 !== 16'h0100) begin
            n_err++;
            $display("FAIL b2b_second: got lat=%0d product=%h expected lat=8 product=0100", lat, prod8);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit saw_done;
        @(negedge clk);
        sm = 1'b0; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0) begin
            n_err++;
            $display("FAIL abort_state: got busy=%b done=%b product=%h expected 0 0 0000",
                     busy8, done8, prod8);
        end
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done) begin
            n_err++;
            $display("FAIL abort_no_done: got activity after abort expected none");
        end
        op8(1'b0, 1'b0, 8'h03, 8'h05, 16'h000F, 8, "abort_restart");
    endtask

    task automatic test_wide();
        logic [15:0] corners [3] = '{16'h8000, 16'h7FFF, 16'hFFFF};
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    op16(s[0], corners[i], corners[j]);
        for (int k = 0; k < 1000; k++)
            op16(1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom));
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Clocked, parametrised shift-and-add multiplier. Processes one multiplier bit per cycle.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Uses a start/busy/done handshake and holds the registered result until the next operation.
- Next-generation replacement for the start-edge-triggered 8-bit multiplier. Intended for area-constrained datapaths where a WIDTH-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand width in bits (2..32).
- EARLY_ZERO, 1, when 1 a zero operand completes in one cycle; when 0 all operations take WIDTH cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new multiply; sampled only in IDLE or DONE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- operand_a  input  WIDTH  multiplicand; captured with start.
- operand_b  input  WIDTH  multiplier; captured with start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  registered result; held until the next completion.

Behaviour:
- Reset: synchronous, active-high. When rst=1 at a clock edge:
  - state returns to IDLE;
  - product, busy, done and all internal registers go to 0;
  - reset overrides start and aborts any operation in progress. No done is issued for an aborted operation.
- States: IDLE, BUSY, DONE.
- IDLE/DONE, start=1 at edge E:
  - operands and signed_mode are latched;
  - accumulator (WIDTH+1 bits) is cleared;
  - bit counter is loaded with WIDTH;
  - busy=1, done=0, next state BUSY.
- Zero shortcut: if EARLY_ZERO=1 and either operand is 0 at edge E:
  - no BUSY phase;
  - at edge E: product=0, done=1, busy=0, next state DONE.
- BUSY, one iteration per edge, edges E+1 .. E+WIDTH:
  - if the current multiplier LSB is 1, add the multiplicand into the accumulator;
  - the subtraction rule below applies on the final iteration;
  - shift {accumulator, multiplier} right by 1, arithmetic in signed mode, logical in unsigned mode;
  - decrement the counter.
- Signed mode:
  - multiplicand is sign-extended to WIDTH+1 bits;
  - on the final iteration, if the multiplier MSB is 1, the multiplicand is subtracted instead of added;
  - the result is the exact two's-complement product.
- Unsigned mode: multiplicand is zero-extended; the result is the exact unsigned product.
- Completion, at edge E+WIDTH:
  - product = low 2*WIDTH bits of the combined register;
  - busy=0, done=1, next state DONE.
  - Latency from the start-sampling edge to done is WIDTH cycles.
- DONE:
  - done stays high exactly one cycle;
  - with start=0 the next state is IDLE and done=0;
  - with start=1 a new operation is accepted at that edge (back-to-back, no bubble).
- Ignored inputs:
  - start while BUSY is ignored; the operation in progress is unaffected;
  - operand and mode changes while BUSY have no effect.
- Output stability: product changes only at completion or reset, never mid-operation.
- Corner values: most-negative × most-negative in signed mode yields +2^(2*WIDTH-2) with no overflow, since the 2*WIDTH-bit result always fits.
- Counter width is clog2(WIDTH+1). No arithmetic wrap is permitted in the accumulator, which is WIDTH+1 bits.

Test Plan:
- WIDTH=8, unsigned, 0xFF × 0xFF:
  - busy high 8 cycles;
  - done pulses exactly 8 cycles after the start edge;
  - product=0xFE01.
- WIDTH=8, signed:
  - 0x80 × 0x80 -> 0x4000;
  - 0x7F × 0x80 -> 0xC080;
  - 0xFF × 0x01 -> 0xFFFF;
  - the same 0xFF × 0x01 in unsigned mode -> 0x00FF.
- Zero shortcut:
  - EARLY_ZERO=1, 0x00 × 0x5A -> done on the start edge, product=0x0000, busy never high;
  - EARLY_ZERO=0, same operands -> done after 8 cycles, product=0x0000.
- Handshake:
  - pulse start again mid-BUSY with different operands -> ignored, first result 0x37×0x12=0x03DE delivered;
  - start held high during the DONE cycle -> second operation begins immediately, next done 8 cycles later.
- Reset:
  - assert rst at cycle 4 of BUSY -> next edge: busy=0, done=0, product=0, state IDLE;
  - no done pulse follows;
  - a subsequent start works normally.
- WIDTH=16, signed, random 1000 operand pairs plus corners 0x8000, 0x7FFF, 0xFFFF:
  - product equals the reference signed/unsigned model;
  - done latency is 16 cycles throughout.
